// File: rtl/light_phase_sequencer.sv
// Timed RED -> GREEN -> YELLOW light sequencer with prescaled dwell and pedestrian shortening.
// Define LIGHT_ALLRED_EN to insert an all-red clearance phase between YELLOW and RED.
module light_phase_sequencer #(
    parameter int PRESCALE     = 4,
    parameter int RED_TICKS    = 2,
    parameter int GREEN_TICKS  = 3,
    parameter int YELLOW_TICKS = 1,
    parameter int PED_CUT      = 1,
    parameter int ALLRED_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ped_req,
    output logic [1:0] phase,
    output logic [2:0] light,
    output logic       tick,
    output logic       ped_ack
);

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_ALLRED = 2'b11
    } phase_t;

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MAX1 = (RED_TICKS > GREEN_TICKS) ? RED_TICKS : GREEN_TICKS;
    localparam int MAX2 = (MAX1 > YELLOW_TICKS) ? MAX1 : YELLOW_TICKS;
    localparam int MAXT = (MAX2 > ALLRED_TICKS) ? MAX2 : ALLRED_TICKS;
    localparam int DW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] RED_LOAD    = DW'(RED_TICKS - 1);
    localparam logic [DW-1:0] GREEN_LOAD  = DW'(GREEN_TICKS - 1);
    localparam logic [DW-1:0] YELLOW_LOAD = DW'(YELLOW_TICKS - 1);
    localparam logic [DW-1:0] ALLRED_LOAD = DW'(ALLRED_TICKS - 1);
    localparam logic [DW-1:0] CUT_LOAD    = DW'(PED_CUT - 1);

    phase_t        phase_q, phase_next;
    logic [PW-1:0] presc_q, presc_next;
    logic [DW-1:0] dwell_q, dwell_next, dwell_dec;
    logic          pending_q, pending_next;
    logic          ack_next;
    logic          illegal;
    logic          enter_red;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= PH_RED;
            presc_q   <= '0;
            dwell_q   <= RED_LOAD;
            pending_q <= 1'b0;
            ped_ack   <= 1'b0;
        end else begin
            phase_q   <= phase_next;
            presc_q   <= presc_next;
            dwell_q   <= dwell_next;
            pending_q <= pending_next;
            ped_ack   <= ack_next;
        end
    end

`ifdef LIGHT_ALLRED_EN
    assign illegal = 1'b0;
`else
    assign illegal = (phase_q == PH_ALLRED);
`endif

    assign tick      = enable && (presc_q == PRE_LAST);
    assign dwell_dec = dwell_q - DW'(1);

    always_comb begin
        presc_next = presc_q;
        phase_next = phase_q;
        dwell_next = dwell_q;
        if (enable) begin
            presc_next = tick ? '0 : presc_q + PW'(1);
        end
        if (illegal) begin
            phase_next = PH_RED;
            dwell_next = RED_LOAD;
        end else if (tick) begin
            if (dwell_q == '0) begin
                case (phase_q)
                    PH_RED: begin
                        phase_next = PH_GREEN;
                        dwell_next = GREEN_LOAD;
                    end
                    PH_GREEN: begin
                        phase_next = PH_YELLOW;
                        dwell_next = YELLOW_LOAD;
                    end
`ifdef LIGHT_ALLRED_EN
                    PH_YELLOW: begin
                        phase_next = PH_ALLRED;
                        dwell_next = ALLRED_LOAD;
                    end
`else
                    PH_YELLOW: begin
                        phase_next = PH_RED;
                        dwell_next = RED_LOAD;
                    end
`endif
                    default: begin
                        phase_next = PH_RED;
                        dwell_next = RED_LOAD;
                    end
                endcase
            end else if (phase_q == PH_GREEN && pending_q && dwell_dec > CUT_LOAD) begin
                // A pending request can only pull the end of GREEN closer, never push it out
                dwell_next = CUT_LOAD;
            end else begin
                dwell_next = dwell_dec;
            end
        end
    end

    // Entering RED serves any request, including one arriving on that same edge
    always_comb begin
        enter_red    = (phase_next == PH_RED) && (phase_q != PH_RED);
        pending_next = enter_red ? 1'b0 : (pending_q | ped_req);
        ack_next     = enter_red && (pending_q || ped_req);
    end

    always_comb begin
        light = 3'b001;
        case (phase_q)
            PH_GREEN:  light = 3'b100;
            PH_YELLOW: light = 3'b010;
            default:   light = 3'b001;
        endcase
    end

    assign phase = phase_q;

endmodule

// File: doc/light_phase_sequencer.md
Name: light_phase_sequencer

Overview:
- Timed phase controller for the 3-state light: sequences RED -> GREEN -> YELLOW -> RED with a programmable dwell per phase.
- Contains a clock-enable prescaler that replaces the ripple divider, a per-phase dwell counter, and a sticky pedestrian request that shortens GREEN.
- Phase encoding matches the existing 2-bit light counter: 00 RED, 01 GREEN, 10 YELLOW. Downstream lamp drivers consume phase/light directly.

Parameters:
- PRESCALE, 4, enabled clk cycles per tick (>=1)
- RED_TICKS, 2, RED dwell in ticks (>=1)
- GREEN_TICKS, 3, GREEN dwell in ticks (>=1)
- YELLOW_TICKS, 1, YELLOW dwell in ticks (>=1)
- PED_CUT, 1, max GREEN ticks remaining once a pedestrian request is pending (1..GREEN_TICKS)
- ALLRED_TICKS, 1, clearance dwell in ticks; used only with LIGHT_ALLRED_EN

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = run; 0 = freeze prescaler and dwell counter
- ped_req  in  1  pedestrian request, level or pulse, sampled each edge
- phase  out  2  registered current phase
- light  out  3  {green,yellow,red}, one-hot, decoded from phase register
- tick  out  1  combinational strobe: enable && prescaler==PRESCALE-1
- ped_ack  out  1  registered one-cycle pulse when RED is entered with a request pending or arriving

Behaviour:
- Reset (async, immediate): phase=00, light=001, prescaler=0, dwell=RED_TICKS-1, ped_pending=0, ped_ack=0, tick=0.
- Prescaler: on each edge with enable=1, increments; wraps PRESCALE-1 -> 0. With enable=0 it holds.
- Dwell: on a tick edge with dwell!=0, dwell decrements. On a tick edge with dwell==0, phase advances and dwell loads next_phase_TICKS-1.
- Phase lasts exactly phase_TICKS*PRESCALE enabled cycles. Full period is (R+G+Y)*PRESCALE enabled cycles.
- Transitions: RED->GREEN->YELLOW->RED. Phase 11 is unreachable without the macro; if reached, it is forced to RED on the next edge.
- light decode: 00->001, 01->100, 10->010, 11->001. Never all-off, never more than one lamp on.
- ped_pending: set on any edge with ped_req=1, cleared on the edge that enters RED.
  - Entering RED with ped_pending=1 or ped_req=1 on that edge: ped_ack=1 for one cycle, pending cleared. The request counts as served; clear wins over set.
- GREEN shortening: on a tick edge in GREEN with ped_pending=1 and dwell!=0, dwell <= min(dwell-1, PED_CUT-1). The request never lengthens GREEN and has no effect in other phases.
- Reset mid-phase: outputs return to reset values immediately. After release, RED runs its full dwell.
- Tick-free edges leave phase and dwell unchanged. enable may toggle on any cycle; the frozen time is added to the current phase exactly.

Optional Feature:
- Macro LIGHT_ALLRED_EN.
- Defined:
  - Adds an ALLRED clearance phase 11 between YELLOW and RED: YELLOW->ALLRED->RED.
  - ALLRED dwell is ALLRED_TICKS*PRESCALE cycles; light=001 during ALLRED.
  - ped_ack still fires on RED entry, not ALLRED entry. ped_req during ALLRED sets pending and is acked at RED entry.
- Undefined: ALLRED_TICKS is ignored, YELLOW goes directly to RED, and phase 11 is never produced.

Test Plan:
- Defaults, reset release, enable=1 held -> RED 8 cycles, GREEN 12, YELLOW 4, RED again; tick every 4th cycle; ped_ack never asserts.
- enable=0 for 5 cycles in the middle of GREEN -> tick low throughout, prescaler and dwell hold, GREEN lasts 17 cycles.
- ped_req 1-cycle pulse at GREEN cycle 1 -> first tick sets dwell 0, GREEN lasts 8 cycles, YELLOW 4, ped_ack single pulse on the RED entry cycle, pending=0 afterwards.
- ped_req asserted exactly on the RED-entry edge -> ped_ack pulse, pending stays 0, next GREEN full 12 cycles.
- reset pulsed asynchronously mid-YELLOW (between edges) -> phase=00, light=001 before the next edge; after release RED lasts 8 cycles.
- LIGHT_ALLRED_EN defined, ALLRED_TICKS=2 -> YELLOW 4 cycles, phase 11 with light=001 for 8 cycles, then RED 8; period 32 cycles.
